// File: rtl/rv_pkg.sv
// Shared RV32I encoder types: instruction formats, base opcodes and serializer states.
package rv_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] JAL    = 7'h6F;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B0   = 3'd1,
    B1   = 3'd2,
    B2   = 3'd3,
    B3   = 3'd4
  } state_t;

  // Codes 6 and 7 have no format assigned.
  function automatic logic fmt_legal(input logic [2:0] fmt);
    return fmt <= 3'(FMT_J);
  endfunction

endpackage

// File: rtl/ins_pack.sv
// Combinational RV32I field packer. With INS_ENCODER_IMM_CHECK_EN defined, range_err
// flags immediates that do not fit their format; otherwise immediates are truncated.
module ins_pack
  import rv_pkg::*;
(
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic [WORD_W-1:0] word,
  output logic              range_err
);

  // Bit placement per format; illegal format codes pack to zero.
  always_comb begin
    word = '0;
    case (fmt)
      FMT_R:   word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:   word = {imm[31:12], rd, opcode};
      FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: word = '0;
    endcase
  end

`ifdef INS_ENCODER_IMM_CHECK_EN
  logic sext12_ok;
  logic sext13_ok;
  logic sext21_ok;

  // A value fits N signed bits when every bit above N-1 copies the sign bit.
  assign sext12_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign sext13_ok = (&imm[31:12]) | ~(|imm[31:12]);
  assign sext21_ok = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    range_err = 1'b0;
    case (fmt)
      FMT_I, FMT_S: range_err = ~sext12_ok;
      FMT_B:        range_err = ~sext13_ok | imm[0];
      FMT_J:        range_err = ~sext21_ok | imm[0];
      FMT_U:        range_err = |imm[11:0];
      default:      range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: rtl/ins_encoder.sv
// RV32I instruction encoder: accepts one field bundle, emits the packed word as four
// little-endian bytes with addresses. INS_ENCODER_IMM_CHECK_EN enables immediate range errors.
module ins_encoder
  import rv_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              err
);

  logic [WORD_W-1:0] packed_word;
  logic              range_err;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] addr_d;
  logic              err_d;
  logic              in_ready_d;
  logic              out_valid_d;
  logic              out_last_d;
  logic [BYTE_W-1:0] out_byte_d;
  logic              accept_c;
  logic              hs_c;

  ins_pack u_pack (
    .fmt       (in_fmt),
    .opcode    (in_opcode),
    .rd        (in_rd),
    .rs1       (in_rs1),
    .rs2       (in_rs2),
    .funct3    (in_funct3),
    .funct7    (in_funct7),
    .imm       (in_imm),
    .word      (packed_word),
    .range_err (range_err)
  );

  // State, word, address counter, sticky error and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      word_q    <= '0;
      out_addr  <= BASE_ADDR;
      err       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_byte  <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      out_addr  <= addr_d;
      err       <= err_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      out_byte  <= out_byte_d;
    end
  end

  // Next state plus next values of the registered outputs, derived from that next state.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    addr_d      = out_addr;
    err_d       = err;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_byte_d  = '0;

    accept_c = in_valid & in_ready;
    hs_c     = out_valid & out_ready;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          word_d  = packed_word;
          err_d   = err | ~fmt_legal(in_fmt) | range_err;
          state_d = B0;
        end
      end
      B0:      if (hs_c) state_d = B1;
      B1:      if (hs_c) state_d = B2;
      B2:      if (hs_c) state_d = B3;
      B3:      if (hs_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (hs_c) begin
      addr_d = out_addr + ADDR_W'(1);
    end

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d != IDLE);
    out_last_d  = (state_d == B3);
    case (state_d)
      B0:      out_byte_d = word_d[7:0];
      B1:      out_byte_d = word_d[15:8];
      B2:      out_byte_d = word_d[23:16];
      B3:      out_byte_d = word_d[31:24];
      default: out_byte_d = '0;
    endcase
  end

endmodule

// File: tb/tb_ins_encoder.sv
// Self-checking bench for ins_encoder: directed cases plus randomized words against
// a field-arithmetic reference model; a second instance with ADDR_W=2 shadows the first.
module tb_ins_encoder;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_ready;

  logic        in_ready, out_valid, out_last, err;
  logic [7:0]  out_byte;
  logic [15:0] out_addr;
  logic        w_in_ready, w_out_valid, w_out_last, w_err;
  logic [7:0]  w_out_byte;
  logic [1:0]  w_out_addr;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_addr;
  bit exp_err;

  ins_encoder u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_addr(out_addr), .out_last(out_last), .err(err)
  );

  ins_encoder #(.ADDR_W(2)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_byte(w_out_byte),
    .out_addr(w_out_addr), .out_last(w_out_last), .err(w_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  // Reference encoding built from shifted and masked field values.
  function automatic logic [31:0] ref_word(input int fmt, input int op, input int rd,
                                           input int rs1, input int rs2, input int f3,
                                           input int f7, input logic [31:0] imm);
    logic [31:0] o, d, s1, s2, fn3, fn7;
    o   = 32'(op)  & 32'h7F;
    d   = 32'(rd)  & 32'h1F;
    s1  = 32'(rs1) & 32'h1F;
    s2  = 32'(rs2) & 32'h1F;
    fn3 = 32'(f3)  & 32'h7;
    fn7 = 32'(f7)  & 32'h7F;
    case (fmt)
      0: return (fn7 << 25) | (s2 << 20) | (s1 << 15) | (fn3 << 12) | (d << 7) | o;
      1: return ((imm & 32'hFFF) << 20) | (s1 << 15) | (fn3 << 12) | (d << 7) | o;
      2: return (((imm >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) | (fn3 << 12)
              | ((imm & 32'h1F) << 7) | o;
      3: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (s2 << 20)
              | (s1 << 15) | (fn3 << 12) | (((imm >> 1) & 32'hF) << 8)
              | (((imm >> 11) & 32'h1) << 7) | o;
      4: return (imm & 32'hFFFFF000) | (d << 7) | o;
      5: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
              | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (d << 7) | o;
      default: return 32'h0;
    endcase
  endfunction

  // Immediate range violation, only meaningful when the check build is selected.
  function automatic bit ref_imm_err(input int fmt, input logic [31:0] imm);
    int s;
    bit chk;
    bit en;
    s = $signed(imm);
    case (fmt)
      1, 2:    chk = (s < -2048) || (s > 2047);
      3:       chk = (s < -4096) || (s > 4094) || ((s & 1) != 0);
      4:       chk = (s & 32'hFFF) != 0;
      5:       chk = (s < -1048576) || (s > 1048574) || ((s & 1) != 0);
      default: chk = 1'b0;
    endcase
`ifdef INS_ENCODER_IMM_CHECK_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    return en && chk;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_addr = 0;
    exp_err  = 1'b0;
  endtask

  // Drives one bundle and collects the four bytes; called and left at a falling edge.
  task automatic run_word(input int fmt, input int op, input int rd, input int rs1,
                          input int rs2, input int f3, input int f7, input logic [31:0] imm,
                          input int mode,
                          output logic [31:0] w, output logic [63:0] a, output logic [7:0] wa,
                          output logic [3:0] lst, output int stall_viol, output int ready_viol,
                          output int twin_viol, output int lat_bad, output int tmo);
    int k, n, cyc;
    bit hold, r;
    logic [7:0]  hb;
    logic [15:0] ha;
    logic        hl;
    w = '0; a = '0; wa = '0; lst = '0; hb = '0; ha = '0; hl = 1'b0;
    stall_viol = 0; ready_viol = 0; twin_viol = 0; lat_bad = 0; tmo = 0;
    in_fmt = 3'(fmt); in_opcode = 7'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_funct3 = 3'(f3); in_funct7 = 7'(f7); in_imm = imm;
    in_valid = 1'b1; out_ready = 1'b0;
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    if (in_ready !== 1'b1) begin tmo = 1; in_valid = 1'b0; return; end
    @(negedge clk);
    in_valid = 1'b0;
    in_imm = $urandom; in_rd = 5'($urandom); in_opcode = 7'($urandom);
    lat_bad = (out_valid !== 1'b1) ? 1 : 0;
    n = 0; cyc = 0; hold = 1'b0; k = 0;
    while (n < 4 && cyc < 100) begin
      if (out_valid && hold && ({out_byte, out_addr, out_last} !== {hb, ha, hl})) stall_viol++;
      if (in_ready !== 1'b0) ready_viol++;
      if (w_out_valid !== out_valid || w_in_ready !== in_ready || w_out_byte !== out_byte ||
          w_out_last !== out_last || w_err !== err || w_out_addr !== out_addr[1:0]) twin_viol++;
      r = (mode == 0) ? 1'b1 : (mode == 1) ? ((k % 3) == 0) : 1'($urandom_range(0, 1));
      k++;
      out_ready = r;
      if (out_valid) begin
        if (r) begin
          w[8*n +: 8] = out_byte; a[16*n +: 16] = out_addr; wa[2*n +: 2] = w_out_addr;
          lst[n] = out_last; n++; hold = 1'b0;
        end else begin
          hold = 1'b1; hb = out_byte; ha = out_addr; hl = out_last;
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (n < 4) tmo = 1;
    out_ready = 1'b0;
  endtask

  function automatic logic [63:0] exp_addrs(input int base);
    logic [63:0] e;
    for (int i = 0; i < 4; i++) e[16*i +: 16] = 16'(base + i);
    return e;
  endfunction

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({in_ready, out_valid, out_last, err, out_byte, out_addr, w_out_addr} !== {4'b1000, 8'h00, 16'h0000, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b last=%b err=%b byte=%h addr=%h waddr=%h, want 1 0 0 0 00 0000 0",
               in_ready, out_valid, out_last, err, out_byte, out_addr, w_out_addr);
    end
  endtask

  task automatic test_addi();
    logic [31:0] w; logic [63:0] a; logic [7:0] wa; logic [3:0] l; int sv, rv, tv, lb, tm;
    run_word(1, 'h13, 1, 0, 0, 0, 0, 32'd5, 0, w, a, wa, l, sv, rv, tv, lb, tm);
    n_cmp++; if (tm != 0 || lb != 0) begin n_fail++; $display("FAIL addi_latency: timeout=%0d late=%0d, want 0 0", tm, lb); end
    n_cmp++; if (w !== 32'h00500093) begin n_fail++; $display("FAIL addi_word: got %h want 00500093", w); end
    n_cmp++; if (a !== exp_addrs(exp_addr)) begin n_fail++; $display("FAIL addi_addr: got %h want %h", a, exp_addrs(exp_addr)); end
    n_cmp++; if (l !== 4'b1000) begin n_fail++; $display("FAIL addi_last: got %b want 1000", l); end
    n_cmp++; if (err !== 1'b0 || rv != 0 || tv != 0) begin n_fail++; $display("FAIL addi_flags: err=%b rdy_viol=%0d twin=%0d, want 0 0 0", err, rv, tv); end
    exp_addr += 4;
  endtask

  task automatic test_stall();
    logic [31:0] w; logic [63:0] a; logic [7:0] wa; logic [3:0] l; int sv, rv, tv, lb, tm;
    run_word(0, 'h33, 3, 1, 2, 0, 0, 32'd0, 1, w, a, wa, l, sv, rv, tv, lb, tm);
    n_cmp++; if (w !== 32'h002081B3 || tm != 0) begin n_fail++; $display("FAIL add_word: got %h tmo=%0d want 002081b3 0", w, tm); end
    n_cmp++; if (sv != 0) begin n_fail++; $display("FAIL add_stall_stable: got %0d changes want 0", sv); end
    n_cmp++; if (a !== exp_addrs(exp_addr) || l !== 4'b1000) begin n_fail++; $display("FAIL add_addr: got %h/%b want %h/1000", a, l, exp_addrs(exp_addr)); end
    exp_addr += 4;
  endtask

  task automatic test_branch_jal();
    logic [31:0] w; logic [63:0] a; logic [7:0] wa; logic [3:0] l; int sv, rv, tv, lb, tm;
    run_word(3, 'h63, 0, 0, 0, 0, 0, 32'd8, 2, w, a, wa, l, sv, rv, tv, lb, tm);
    n_cmp++; if (w !== 32'h00000463 || a !== exp_addrs(exp_addr)) begin n_fail++; $display("FAIL beq_word: got %h @%h want 00000463 @%h", w, a, exp_addrs(exp_addr)); end
    n_cmp++; if (rv != 0 || tm != 0) begin n_fail++; $display("FAIL beq_in_ready: got rdy_viol=%0d tmo=%0d want 0 0", rv, tm); end
    exp_addr += 4;
    run_word(5, 'h6F, 0, 0, 0, 0, 0, 32'd0, 2, w, a, wa, l, sv, rv, tv, lb, tm);
    n_cmp++; if (w !== 32'h0000006F || a !== exp_addrs(exp_addr)) begin n_fail++; $display("FAIL jal_word: got %h @%h want 0000006f @%h", w, a, exp_addrs(exp_addr)); end
    n_cmp++; if (rv != 0 || tm != 0 || sv != 0) begin n_fail++; $display("FAIL jal_in_ready: got rdy_viol=%0d tmo=%0d stall=%0d want 0 0 0", rv, tm, sv); end
    exp_addr += 4;
  endtask

  task automatic test_imm_check();
    logic [31:0] w; logic [63:0] a; logic [7:0] wa; logic [3:0] l; int sv, rv, tv, lb, tm;
    do_reset();
    run_word(1, 'h13, 2, 3, 0, 0, 0, 32'd2048, 0, w, a, wa, l, sv, rv, tv, lb, tm);
    exp_err = exp_err | ref_imm_err(1, 32'd2048);
    n_cmp++; if (w !== ref_word(1, 'h13, 2, 3, 0, 0, 0, 32'd2048)) begin n_fail++; $display("FAIL imm2048_word: got %h want %h", w, ref_word(1, 'h13, 2, 3, 0, 0, 0, 32'd2048)); end
    n_cmp++; if (err !== exp_err) begin n_fail++; $display("FAIL imm2048_err: got %b want %b", err, exp_err); end
    exp_addr += 4;
    run_word(1, 'h13, 1, 0, 0, 0, 0, 32'd5, 0, w, a, wa, l, sv, rv, tv, lb, tm);
    n_cmp++; if (err !== exp_err) begin n_fail++; $display("FAIL imm_err_sticky: got %b want %b", err, exp_err); end
    do_reset();
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL imm_err_cleared: got %b want 0", err); end
  endtask

  task automatic test_illegal();
    logic [31:0] w; logic [63:0] a; logic [7:0] wa; logic [3:0] l; int sv, rv, tv, lb, tm;
    for (int f = 6; f < 8; f++) begin
      run_word(f, 'h33, 7, 7, 7, 7, 7, 32'hFFFF_FFFF, 2, w, a, wa, l, sv, rv, tv, lb, tm);
      n_cmp++; if (w !== 32'h0 || l !== 4'b1000 || tm != 0) begin n_fail++; $display("FAIL illegal_fmt%0d_word: got %h last=%b tmo=%0d want 00000000 1000 0", f, w, l, tm); end
      n_cmp++; if (err !== 1'b1 || a !== exp_addrs(exp_addr)) begin n_fail++; $display("FAIL illegal_fmt%0d_err: got err=%b @%h want 1 @%h", f, err, a, exp_addrs(exp_addr)); end
      exp_addr += 4;
    end
    exp_err = 1'b1;
  endtask

  task automatic test_wrap();
    logic [31:0] w; logic [63:0] a; logic [7:0] wa; logic [3:0] l; int sv, rv, tv, lb, tm;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      run_word(4, 'h37, 9, 0, 0, 0, 0, 32'h1234_5000, 2, w, a, wa, l, sv, rv, tv, lb, tm);
      n_cmp++; if (wa !== 8'b11_10_01_00 || tv != 0) begin n_fail++; $display("FAIL wrap_word%0d: got addrs %b twin=%0d want 11100100 0", i, wa, tv); end
      exp_addr += 4;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wa_w, wb_w, ew;
    bit er, ev;
    int ea;
    wa_w = ref_word(0, 'h33, 5, 6, 7, 2, 'h20, 32'd0);
    wb_w = ref_word(1, 'h13, 8, 9, 0, 4, 0, 32'hFFFF_FFF0);
    in_fmt = 3'd0; in_opcode = 7'h33; in_rd = 5'd5; in_rs1 = 5'd6; in_rs2 = 5'd7;
    in_funct3 = 3'd2; in_funct7 = 7'h20; in_imm = 32'd0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      ev = (c >= 1 && c <= 4) || (c >= 6 && c <= 9);
      er = !ev;
      ew = (c <= 4) ? wa_w : wb_w;
      ea = exp_addr + ((c <= 4) ? c - 1 : c - 2);
      n_cmp++;
      if (in_ready !== er || out_valid !== ev ||
          (ev && (out_byte !== ew[8*((c <= 4) ? c - 1 : c - 6) +: 8] || out_addr !== 16'(ea)))) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got rdy=%b vld=%b byte=%h addr=%h want rdy=%b vld=%b", c,
                 in_ready, out_valid, out_byte, out_addr, er, ev);
      end
      if (c == 1) begin
        in_fmt = 3'd1; in_opcode = 7'h13; in_rd = 5'd8; in_rs1 = 5'd9; in_funct3 = 3'd4;
        in_imm = 32'hFFFF_FFF0;
      end
      if (c == 6) in_valid = 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b0;
    exp_addr += 8;
  endtask

  task automatic test_mid_reset();
    in_fmt = 3'd7; in_opcode = 7'h33; in_imm = 32'd0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (out_addr !== 16'(exp_addr + 2) || err !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got addr=%h err=%b want %h 1", out_addr, err, 16'(exp_addr + 2)); end
    rst = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || out_addr !== 16'h0 || err !== 1'b0 || out_last !== 1'b0) begin n_fail++; $display("FAIL midrst_flush: got vld=%b addr=%h err=%b last=%b want 0 0000 0 0", out_valid, out_addr, err, out_last); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
    exp_addr = 0; exp_err = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] w, imm, r, ew; logic [63:0] a; logic [7:0] wa; logic [3:0] l;
    int sv, rv, tv, lb, tm, fmt, op, rd, rs1, rs2, f3, f7, md;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      fmt = $urandom_range(0, 5); op = $urandom_range(0, 127); rd = $urandom_range(0, 31);
      rs1 = $urandom_range(0, 31); rs2 = $urandom_range(0, 31); f3 = $urandom_range(0, 7);
      f7 = $urandom_range(0, 127); md = $urandom_range(0, 2);
      r = $urandom;
      imm = ($urandom_range(0, 1) == 1) ? {{20{r[11]}}, r[11:1], 1'b0} : $urandom;
      ew = ref_word(fmt, op, rd, rs1, rs2, f3, f7, imm);
      exp_err = exp_err | ref_imm_err(fmt, imm);
      run_word(fmt, op, rd, rs1, rs2, f3, f7, imm, md, w, a, wa, l, sv, rv, tv, lb, tm);
      n_cmp++;
      if (w !== ew || a !== exp_addrs(exp_addr) || l !== 4'b1000 || err !== exp_err) begin
        n_fail++;
        $display("FAIL rand%0d_word: fmt=%0d imm=%h got %h @%h last=%b err=%b want %h @%h 1000 err=%b",
                 i, fmt, imm, w, a, l, err, ew, exp_addrs(exp_addr), exp_err);
      end
      n_cmp++;
      if (sv != 0 || rv != 0 || tv != 0 || lb != 0 || tm != 0) begin
        n_fail++;
        $display("FAIL rand%0d_protocol: stall=%0d rdy=%0d twin=%0d late=%0d tmo=%0d want all 0",
                 i, sv, rv, tv, lb, tm);
      end
      exp_addr += 4;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    exp_addr = 0; exp_err = 1'b0;
    @(negedge clk);
    test_reset();
    test_addi();
    test_stall();
    test_branch_jal();
    test_back_to_back();
    test_imm_check();
    test_illegal();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
